// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared state encoding and register defaults for counter_load_ctrl
package counter_ctrl_pkg;

  // Control states: HOLD freezes the counter, PRELOAD applies the preset, RUN counts
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_RUN     = 2'd2
  } ctrl_state_e;

  // Widest count supported; users slice the defaults down to their WIDTH
  localparam int MAX_WIDTH = 32;

  // Preset defaults to zero, terminal value defaults to all ones (full-range count)
  localparam logic [MAX_WIDTH-1:0] DEF_PRESET = '0;
  localparam logic [MAX_WIDTH-1:0] DEF_LIMIT  = '1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating incrementer with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  // Clear wins over increment; increment sticks once all ones is reached
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      r_value <= '0;
    end else if (inc && (r_value != {W{1'b1}})) begin
      r_value <= r_value + W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/counter_load_ctrl.sv
// rtl/counter_load_ctrl.sv - start/stop, preset and terminal-count control for a loadable counter
module counter_load_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_preset,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic                  start,
  input  logic                  stop,
  input  logic [WIDTH-1:0]      count,
  output logic                  load,
  output logic [WIDTH-1:0]      load_data,
  output logic                  wrap,
  output logic                  running,
  output logic [WRAP_CNT_W-1:0] wrap_count
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_next_state;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_limit;
  logic             w_cfg_fire;
  logic             w_wc_clr;
  logic             w_wc_inc;

  assign w_cfg_fire = cfg_valid & cfg_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Preset/limit capture; only possible in HOLD because cfg_ready is low elsewhere
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_preset <= DEF_PRESET[WIDTH-1:0];
      r_limit  <= DEF_LIMIT[WIDTH-1:0];
    end else if (w_cfg_fire) begin
      r_preset <= cfg_preset;
      r_limit  <= cfg_limit;
    end
  end

  // Next state and zero-latency counter controls; holding means reloading count
  always_comb begin
    w_next_state = r_state;
    load         = 1'b1;
    load_data    = count;
    cfg_ready    = 1'b0;
    running      = 1'b0;
    wrap         = 1'b0;
    w_wc_clr     = 1'b0;
    w_wc_inc     = 1'b0;
    case (r_state)
      ST_HOLD: begin
        cfg_ready = 1'b1;
        if (start && !stop) begin
          w_next_state = ST_PRELOAD;
        end
      end
      ST_PRELOAD: begin
        w_wc_clr = 1'b1;
        if (stop) begin
          w_next_state = ST_HOLD;
        end else begin
          load_data    = r_preset;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        running = 1'b1;
        if (stop) begin
          w_next_state = ST_HOLD;
        end else if (count == r_limit) begin
          load_data = r_preset;
          wrap      = 1'b1;
          w_wc_inc  = 1'b1;
        end else begin
          load = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_HOLD;
      end
    endcase
  end

  sat_counter #(
    .W(WRAP_CNT_W)
  ) u_wrap_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (w_wc_clr),
    .inc    (w_wc_inc),
    .value  (wrap_count)
  );

endmodule

// File: tb/tb_counter_load_ctrl.sv
// tb/tb_counter_load_ctrl.sv - self-checking bench for counter_load_ctrl with a loadable counter model
module tb_counter_load_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_preset;
  logic [3:0] cfg_limit;
  logic       start;
  logic       stop;
  logic [3:0] count;
  logic       load;
  logic [3:0] load_data;
  logic       wrap;
  logic       running;
  logic [7:0] wrap_count;
  logic       cnt_rstn;

  always #5 clk = ~clk;

  counter_load_ctrl #(
    .WIDTH(4),
    .WRAP_CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_preset(cfg_preset),
    .cfg_limit (cfg_limit),
    .start     (start),
    .stop      (stop),
    .count     (count),
    .load      (load),
    .load_data (load_data),
    .wrap      (wrap),
    .running   (running),
    .wrap_count(wrap_count)
  );

  // Downstream 4-bit loadable counter
  always @(posedge clk) begin
    if (!cnt_rstn) count <= 4'd0;
    else if (load) count <= load_data;
    else count <= count + 4'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode flags, captured config, mirrored count and wrap tally
  bit         m_pre, m_run;
  logic [3:0] m_preset, m_limit, m_cnt;
  int         m_wc;

  logic       obs_load, obs_wrap, obs_run, obs_rdy;
  logic [3:0] obs_ld, obs_cnt;
  logic [7:0] obs_wc;

  task automatic step(input logic st, input logic sp, input logic cv,
                      input logic [3:0] pr, input logic [3:0] lm, input logic rn);
    logic       e_load, e_wrap, e_run, e_rdy;
    logic [3:0] e_ld;
    start = st; stop = sp; cfg_valid = cv; cfg_preset = pr; cfg_limit = lm; reset_n = rn;
    #1;
    e_rdy = 1'b0; e_run = 1'b0; e_wrap = 1'b0; e_load = 1'b1; e_ld = m_cnt;
    if (m_pre) begin
      if (!sp) e_ld = m_preset;
    end else if (m_run) begin
      e_run = 1'b1;
      if (!sp) begin
        if (m_cnt == m_limit) begin
          e_ld = m_preset;
          e_wrap = 1'b1;
        end else begin
          e_load = 1'b0;
        end
      end
    end else begin
      e_rdy = 1'b1;
    end
    obs_load = load; obs_ld = load_data; obs_wrap = wrap; obs_run = running;
    obs_rdy = cfg_ready; obs_cnt = count; obs_wc = wrap_count;
    chk("model_count", count, m_cnt);
    chk("model_load", load, e_load);
    if (e_load) chk("model_load_data", load_data, e_ld);
    chk("model_cfg_ready", cfg_ready, e_rdy);
    chk("model_running", running, e_run);
    chk("model_wrap", wrap, e_wrap);
    chk("model_wrap_count", wrap_count, m_wc);
    @(posedge clk);
    m_cnt = e_load ? e_ld : m_cnt + 4'd1;
    if (!rn) begin
      m_pre = 0; m_run = 0; m_preset = 4'd0; m_limit = 4'd15; m_wc = 0;
    end else if (m_pre) begin
      m_wc = 0; m_pre = 0; m_run = !sp;
    end else if (m_run) begin
      if (sp) m_run = 0;
      else if (e_wrap && m_wc < 255) m_wc++;
    end else begin
      if (cv) begin m_preset = pr; m_limit = lm; end
      if (st && !sp) m_pre = 1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic st, sp, cv;
    logic [3:0] pr, lm;
    logic [3:0] e_cnt;
    logic e_load;
    logic [3:0] e_ld;
    logic e_wrap, e_run, e_rdy;
    logic [7:0] e_wc;
  } vec_t;

  vec_t tv[$];

  initial begin
    reset_n = 0; cnt_rstn = 0; cfg_valid = 0; cfg_preset = 0; cfg_limit = 0;
    start = 0; stop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cnt_rstn = 1;
    m_pre = 0; m_run = 0; m_preset = 4'd0; m_limit = 4'd15; m_cnt = 4'd0; m_wc = 0;

    // Idle after reset: holding, ready, not running
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 4'd0, 4'd0, 1);
      chk("idle_load", obs_load, 1);
      chk("idle_load_data", obs_ld, 0);
      chk("idle_cfg_ready", obs_rdy, 1);
      chk("idle_running", obs_run, 0);
      chk("idle_wrap_count", obs_wc, 0);
    end

    // st sp cv pr lm | cnt load ld wrap run rdy wc
    tv.push_back('{0,0,1,4'd3,4'd7, 4'd0,1,4'd0,0,0,1,8'd0});
    tv.push_back('{1,0,0,4'd0,4'd0, 4'd0,1,4'd0,0,0,1,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd0,1,4'd3,0,0,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd3,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd4,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd5,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd6,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd7,1,4'd3,1,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd3,0,4'd0,0,1,0,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd4,0,4'd0,0,1,0,8'd1});
    tv.push_back('{0,1,0,4'd0,4'd0, 4'd5,1,4'd5,0,1,0,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd5,1,4'd5,0,0,1,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd5,1,4'd5,0,0,1,8'd1});
    tv.push_back('{1,0,0,4'd0,4'd0, 4'd5,1,4'd5,0,0,1,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd5,1,4'd3,0,0,0,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd3,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,1,0,4'd0,4'd0, 4'd4,1,4'd4,0,1,0,8'd0});
    tv.push_back('{1,1,0,4'd0,4'd0, 4'd4,1,4'd4,0,0,1,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd4,1,4'd4,0,0,1,8'd0});
    tv.push_back('{1,0,0,4'd0,4'd0, 4'd4,1,4'd4,0,0,1,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd4,1,4'd3,0,0,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd3,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd4,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd5,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd6,0,4'd0,0,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd7,1,4'd3,1,1,0,8'd0});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd3,0,4'd0,0,1,0,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd4,0,4'd0,0,1,0,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd5,0,4'd0,0,1,0,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd6,0,4'd0,0,1,0,8'd1});
    tv.push_back('{0,1,0,4'd0,4'd0, 4'd7,1,4'd7,0,1,0,8'd1});
    tv.push_back('{0,0,0,4'd0,4'd0, 4'd7,1,4'd7,0,0,1,8'd1});

    foreach (tv[i]) begin
      step(tv[i].st, tv[i].sp, tv[i].cv, tv[i].pr, tv[i].lm, 1);
      chk($sformatf("vec%0d_count", i), obs_cnt, tv[i].e_cnt);
      chk($sformatf("vec%0d_load", i), obs_load, tv[i].e_load);
      if (tv[i].e_load) chk($sformatf("vec%0d_load_data", i), obs_ld, tv[i].e_ld);
      chk($sformatf("vec%0d_wrap", i), obs_wrap, tv[i].e_wrap);
      chk($sformatf("vec%0d_running", i), obs_run, tv[i].e_run);
      chk($sformatf("vec%0d_cfg_ready", i), obs_rdy, tv[i].e_rdy);
      chk($sformatf("vec%0d_wrap_count", i), obs_wc, tv[i].e_wc);
    end

    // Held value stays put for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 4'd0, 4'd0, 1);
      chk("hold_count", obs_cnt, 7);
    end

    // preset == limit: wrap every RUN cycle, tally saturates, cfg held but refused
    step(0, 0, 1, 4'd5, 4'd5, 1);
    step(1, 0, 0, 4'd0, 4'd0, 1);
    step(0, 0, 0, 4'd0, 4'd0, 1);
    chk("sat_preload_data", obs_ld, 5);
    for (int i = 0; i < 300; i++) step(0, 0, 1, 4'd9, 4'd12, 1);
    chk("sat_wrap_count", obs_wc, 255);
    chk("sat_wrap", obs_wrap, 1);
    chk("sat_cfg_ready", obs_rdy, 0);
    step(0, 1, 1, 4'd9, 4'd12, 1);
    chk("sat_stop_cfg_ready", obs_rdy, 0);
    step(0, 0, 1, 4'd9, 4'd12, 1);
    chk("sat_hold_cfg_ready", obs_rdy, 1);
    step(1, 0, 0, 4'd0, 4'd0, 1);
    step(0, 0, 0, 4'd0, 4'd0, 1);
    chk("late_cfg_preset", obs_ld, 9);

    // limit below preset: natural wrap through zero
    step(0, 1, 0, 4'd0, 4'd0, 1);
    step(0, 0, 1, 4'd14, 4'd1, 1);
    step(1, 0, 0, 4'd0, 4'd0, 1);
    step(0, 0, 0, 4'd0, 4'd0, 1);
    chk("low_limit_preload", obs_ld, 14);
    begin
      logic [3:0] exp_seq [5];
      exp_seq[0] = 4'd14; exp_seq[1] = 4'd15; exp_seq[2] = 4'd0;
      exp_seq[3] = 4'd1;  exp_seq[4] = 4'd14;
      for (int i = 0; i < 5; i++) begin
        step(0, 0, 0, 4'd0, 4'd0, 1);
        chk($sformatf("low_limit_count%0d", i), obs_cnt, exp_seq[i]);
        chk($sformatf("low_limit_wrap%0d", i), obs_wrap, (i == 3) ? 1 : 0);
      end
    end

    // Synchronous reset mid-RUN, then defaults in effect
    step(0, 0, 0, 4'd0, 4'd0, 0);
    chk("rst_cycle_running", obs_run, 1);
    step(0, 0, 0, 4'd0, 4'd0, 1);
    chk("post_rst_cfg_ready", obs_rdy, 1);
    chk("post_rst_running", obs_run, 0);
    chk("post_rst_wrap_count", obs_wc, 0);
    step(1, 0, 0, 4'd0, 4'd0, 1);
    step(0, 0, 0, 4'd0, 4'd0, 1);
    chk("post_rst_preset", obs_ld, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 4'd0, 4'd0, 1);
      chk($sformatf("def_limit_wrap%0d", i), obs_wrap, (i == 15) ? 1 : 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 6) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
           4'($urandom), 4'($urandom), ($urandom % 150) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_load_ctrl.md
Name: counter_load_ctrl

Overview:
- Control stage directly upstream of the 4-bit loadable counter. Drives the counter's load and load_data inputs, and takes the counter's count output as feedback.
- Turns a free-running counter into a start/stop counter with a programmable preset, a programmable terminal value and a wrap event.
- Holds the counter by reloading its current value.
- Also keeps a saturating count of wrap events for status.

Parameters:
- WIDTH, 4, width of count, load_data, cfg_preset and cfg_limit.
- WRAP_CNT_W, 8, width of the saturating wrap_count output.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  configuration accepted when cfg_valid and cfg_ready are both high at a clock edge.
- cfg_preset  input  WIDTH  value loaded at start and at each wrap.
- cfg_limit  input  WIDTH  terminal count value.
- start  input  1  single-cycle start request.
- stop  input  1  single-cycle stop request.
- count  input  WIDTH  current counter value, fed back from the counter.
- load  output  1  counter load enable.
- load_data  output  WIDTH  counter load value.
- wrap  output  1  one-cycle pulse on a terminal-count reload.
- running  output  1  high in ST_RUN.
- wrap_count  output  WRAP_CNT_W  saturating number of wraps since the last start.

Behaviour:
- State register: ST_HOLD, ST_PRELOAD, ST_RUN. Reset value is ST_HOLD.
- Register reset values:
  - preset_r = 0.
  - limit_r = all ones.
  - wrap_count = 0.
- While reset_n is low at an edge, the next state takes the reset values above.
- Outputs are combinational from state, registers and count, and are sampled by the counter at the same edge (zero latency).
- ST_HOLD:
  - load=1, load_data=count, so the counter holds its value.
  - cfg_ready=1, running=0, wrap=0.
  - A cfg handshake captures preset_r and limit_r at that edge. The new values are visible from the next cycle.
  - start (with stop low) -> ST_PRELOAD. cfg and start in the same cycle are both honoured; ST_PRELOAD then uses the new preset.
- ST_PRELOAD:
  - load=1, load_data=preset_r, cfg_ready=0.
  - wrap_count clears to 0 at this edge.
  - Next state is ST_RUN, or ST_HOLD if stop is high. On stop, load_data=count instead and the preset is not applied.
- ST_RUN:
  - cfg_ready=0, running=1.
  - If count==limit_r: load=1, load_data=preset_r, wrap=1, and wrap_count increments, saturating at all ones.
  - Otherwise load=0 and the counter self-increments.
  - stop: load=1, load_data=count (freezes the value this cycle), wrap=0, wrap_count unchanged, next state ST_HOLD. Stop has priority over a terminal match in the same cycle.
- start while not in ST_HOLD is ignored.
- start and stop high together: stop wins and start is dropped.
- cfg_valid while cfg_ready=0 is not accepted; the requester must keep it asserted.
- Arithmetic is unsigned modulo 2^WIDTH.
  - limit_r < preset_r: the counter naturally wraps through all ones to 0 before reaching the limit. No special handling.
  - limit_r == preset_r: reload and wrap occur every RUN cycle.
- Synchronous reset asserted mid-RUN returns to ST_HOLD with defaults at the next edge. Outputs during the reset cycle follow the pre-reset state; no extra gating.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state enum ctrl_state_e {ST_HOLD, ST_PRELOAD, ST_RUN};
  - localparams DEF_PRESET = 0 and DEF_LIMIT = all ones, as WIDTH-parameterised functions or constants.
- One natural sub-module: sat_counter, a WRAP_CNT_W saturating incrementer with synchronous clear, used for wrap_count.

Test Plan:
- Reset then idle 5 cycles -> load=1 and load_data==count each cycle, cfg_ready=1, running=0, wrap_count=0.
- cfg preset=3, limit=7, then start -> PRELOAD load_data=3. Count sequence 3,4,5,6,7,3,4, with wrap=1 exactly when count==7; wrap_count=1 after the first wrap.
- While running at count=5, stop -> load=1, load_data=5, ST_HOLD next. Count stays 5 for 10 cycles; start again -> reload to 3 and wrap_count clears.
- start and stop in the same cycle from ST_HOLD -> stays in ST_HOLD, no PRELOAD. Stop in the same cycle as count==limit -> load_data=limit, no wrap, wrap_count unchanged.
- preset=5, limit=5 -> wrap every RUN cycle; run 300 cycles with WRAP_CNT_W=8 -> wrap_count saturates at 255. cfg_valid held during RUN -> not accepted until after stop.
- preset=14, limit=1 -> count 14,15,0,1,14 with wrap at 1. Synchronous reset asserted mid-RUN -> ST_HOLD, preset_r=0, limit_r=15 next cycle.
